// File: rtl/mem_responder.sv
// Line-granular memory responder: fixed-latency READ/WRITE service plus a
// one-deep back-invalidate queue that is drained only between transfers.
package cachepkg;
    typedef enum logic [1:0] {NOP = 2'd0, READ = 2'd1, WRITE = 2'd2} op_t;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCESS  = 3'd1,
        RESPOND = 3'd2,
        HOLD    = 3'd3,
        EVICT   = 3'd4
    } state_t;
endpackage

// Handshake: a READ/WRITE request is taken on the edge where it is seen in IDLE
// with no invalidate pending; valid then pulses once. A request still high after
// that pulse is the same request and must drop before another one is accepted.
module mem_responder #(
    parameter int ADDRBITS   = 32,
    parameter int LINEBITS   = 512,
    parameter int OFFSETBITS = 6,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  request,
    input  cachepkg::op_t         operation,
    input  logic [ADDRBITS-1:0]   addr,
    input  logic [LINEBITS-1:0]   d_in,
    output logic [LINEBITS-1:0]   d_out,
    output logic                  valid,
    input  logic                  inv_req,
    input  logic [ADDRBITS-1:0]   inv_addr,
    output logic                  evict,
    output logic [ADDRBITS-1:0]   evict_addr,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count,
    output cachepkg::state_t      dbg_state
);
    import cachepkg::*;

    localparam int         IDXW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

    logic [LINEBITS-1:0] mem [DEPTH] = '{default: '0};

    state_t              state, next_state;
    logic                start;
    op_t                 op_q;
    logic [IDXW-1:0]     idx_q;
    logic [LINEBITS-1:0] data_q;
    logic [3:0]          lat_cnt;
    logic                inv_pend;
    logic [ADDRBITS-1:0] inv_addr_q;
    logic [15:0]         rd_cnt_q, wr_cnt_q;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^addr;
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign dbg_state = state;

    always_comb begin
        next_state = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                // A pending invalidate wins over any request seen this cycle.
                if (inv_pend) begin
                    next_state = EVICT;
                end else if (request && (operation == READ || operation == WRITE)) begin
                    next_state = ACCESS;
                    start      = 1'b1;
                end
            end
            ACCESS:  if (lat_cnt == 4'd0) next_state = RESPOND;
            RESPOND: next_state = request ? HOLD : IDLE;
            HOLD:    if (!request) next_state = IDLE;
            EVICT:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= NOP;
            idx_q      <= '0;
            data_q     <= '0;
            lat_cnt    <= '0;
            inv_pend   <= 1'b0;
            inv_addr_q <= '0;
            valid      <= 1'b0;
            evict      <= 1'b0;
            evict_addr <= '0;
            d_out      <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state      <= next_state;
            valid      <= (next_state == RESPOND);
            evict      <= (next_state == EVICT);
            evict_addr <= (next_state == EVICT) ? inv_addr_q : '0;

            if (start) begin
                op_q    <= operation;
                idx_q   <= addr[OFFSETBITS +: IDXW];
                data_q  <= d_in;
                lat_cnt <= LAT_INIT;
            end else if (state == ACCESS && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end

            if (next_state == RESPOND && op_q == READ) d_out <= mem[idx_q];

            if (state == RESPOND) begin
                if (op_q == READ && rd_cnt_q != 16'hFFFF)  rd_cnt_q <= rd_cnt_q + 16'd1;
                if (op_q == WRITE && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end

            // A new pulse on the eviction edge re-arms the flag for the next round.
            if (inv_req) begin
                inv_pend   <= 1'b1;
                inv_addr_q <= inv_addr;
            end else if (next_state == EVICT) begin
                inv_pend <= 1'b0;
            end
        end
    end

    // Storage is never touched by reset; a write in flight during reset is dropped.
    always_ff @(posedge clock) begin
        if (!reset && state == RESPOND && op_q == WRITE) mem[idx_q] <= data_q;
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder, checked against a line-array
// model with saturating counters.
module tb_mem_responder;
    import cachepkg::*;

    localparam int AW  = 16;
    localparam int LW  = 64;
    localparam int OB  = 6;
    localparam int DP  = 16;
    localparam int LAT = 4;

    logic          clock = 1'b0;
    logic          reset, request, inv_req, valid, evict;
    op_t           operation;
    logic [AW-1:0] addr, inv_addr, evict_addr;
    logic [LW-1:0] d_in, d_out;
    logic [15:0]   rd_count, wr_count;
    state_t        dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [LW-1:0] model_mem [DP];
    logic [LW-1:0] model_dout;
    int            model_rd, model_wr;

    mem_responder #(
        .ADDRBITS(AW), .LINEBITS(LW), .OFFSETBITS(OB), .DEPTH(DP), .LATENCY(LAT)
    ) dut (
        .clock(clock), .reset(reset), .request(request), .operation(operation),
        .addr(addr), .d_in(d_in), .d_out(d_out), .valid(valid),
        .inv_req(inv_req), .inv_addr(inv_addr), .evict(evict), .evict_addr(evict_addr),
        .rd_count(rd_count), .wr_count(wr_count), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int line_idx(input logic [AW-1:0] a);
        return (int'(a) / (1 << OB)) % DP;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic check_counts(input string tag);
        check({tag, "_rd_count"}, rd_count, model_rd);
        check({tag, "_wr_count"}, wr_count, model_wr);
    endtask

    // One transfer, starting from IDLE with nothing pending. Cycle c is observed
    // just after the c-th edge counted from (and including) the sampling edge;
    // valid must show in cycle LAT+1. request stays high for `hold` edges.
    // inv pulses are placed on edge number inv_at / inv2_at (0 = sampling edge).
    task automatic do_op(input string tag, input op_t op, input logic [AW-1:0] a,
                         input logic [LW-1:0] data, input int hold,
                         input int inv_at, input logic [AW-1:0] inv_a,
                         input int inv2_at, input logic [AW-1:0] inv2_a);
        int last, pulses, first_c;
        logic [LW-1:0] exp_line;
        last = ((hold > LAT + 1) ? hold : LAT + 1) + 1;
        if (op == READ) begin
            exp_line   = model_mem[line_idx(a)];
            model_dout = exp_line;
            model_rd   = sat_inc(model_rd);
        end else begin
            exp_line = model_dout;
            model_mem[line_idx(a)] = data;
            model_wr = sat_inc(model_wr);
        end
        pulses = 0;
        first_c = 0;
        request = 1'b1; operation = op; addr = a; d_in = data;
        for (int c = 1; c <= last; c++) begin
            if (c - 1 == inv_at)  begin inv_req = 1'b1; inv_addr = inv_a;  end
            if (c - 1 == inv2_at) begin inv_req = 1'b1; inv_addr = inv2_a; end
            step();
            inv_req = 1'b0;
            if (c == hold) begin request = 1'b0; operation = NOP; end
            if (valid === 1'b1) begin
                pulses++;
                if (first_c == 0) begin
                    first_c = c;
                    check({tag, "_resp_dout"}, d_out, exp_line);
                end
            end
            check({tag, "_no_evict_in_xfer"}, evict, 1'b0);
            if (c > LAT + 1 && c <= hold) check({tag, "_hold_state"}, dbg_state, HOLD);
        end
        check({tag, "_valid_cycle"}, first_c, LAT + 1);
        check({tag, "_valid_pulses"}, pulses, 1);
        check({tag, "_back_idle"}, dbg_state, IDLE);
        check({tag, "_dout_held"}, d_out, model_dout);
        check_counts(tag);
    endtask

    // Called in the first IDLE cycle with an invalidate pending.
    task automatic expect_evict(input string tag, input logic [AW-1:0] a);
        check({tag, "_evict_wait"}, evict, 1'b0);
        step();
        check({tag, "_evict"}, evict, 1'b1);
        check({tag, "_evict_addr"}, evict_addr, a);
        check({tag, "_evict_state"}, dbg_state, EVICT);
        step();
        check({tag, "_evict_drop"}, evict, 1'b0);
        check({tag, "_evict_addr_zero"}, evict_addr, '0);
        check({tag, "_evict_idle"}, dbg_state, IDLE);
    endtask

    initial begin
        logic [AW-1:0] ra, ia;
        logic [LW-1:0] rd;
        op_t           rop;
        int            rh, ri;

        for (int i = 0; i < DP; i++) model_mem[i] = '0;
        model_dout = '0; model_rd = 0; model_wr = 0;
        reset = 1'b1; request = 1'b0; operation = NOP; addr = '0; d_in = '0;
        inv_req = 1'b0; inv_addr = '0;
        repeat (3) step();
        check("rst_valid", valid, 1'b0);
        check("rst_evict", evict, 1'b0);
        check("rst_evict_addr", evict_addr, '0);
        check("rst_dout", d_out, '0);
        check("rst_state", dbg_state, IDLE);
        check_counts("rst");
        reset = 1'b0;
        step();

        // Write then read back one line.
        do_op("wr40", WRITE, 16'h0040, {8{8'hA5}}, 1, -1, '0, -1, '0);
        do_op("rd40", READ, 16'h0040, '0, 1, -1, '0, -1, '0);
        check("rd40_a5", d_out, {8{8'hA5}});
        check("rd40_rd1", rd_count, 16'd1);
        check("rd40_wr1", wr_count, 16'd1);

        // NOP requests are ignored.
        request = 1'b1; operation = NOP; addr = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            step();
            check("nop_valid", valid, 1'b0);
            check("nop_state", dbg_state, IDLE);
        end
        request = 1'b0;
        step();
        check_counts("nop");

        // Request held well past the response.
        do_op("hold80", READ, 16'h0080, '0, 10, -1, '0, -1, '0);

        // Invalidate during ACCESS is deferred until after the read.
        do_op("inv_acc", READ, 16'h0040, '0, 1, 2, 16'h1000, -1, '0);
        expect_evict("inv_acc", 16'h1000);

        // Second pulse while pending overwrites the address; one eviction only.
        do_op("inv_ovr", READ, 16'h0080, '0, 7, 1, 16'h2000, 6, 16'h3040);
        expect_evict("inv_ovr", 16'h3040);

        // Same-cycle invalidate and request with nothing pending: request proceeds.
        do_op("inv_same", WRITE, 16'h0100, 64'h0123_4567_89AB_CDEF, 1, 0, 16'h4440, -1, '0);
        expect_evict("inv_same", 16'h4440);

        // Already pending: the request is dropped in favour of the eviction.
        inv_req = 1'b1; inv_addr = 16'h5500;
        step();
        inv_req = 1'b0;
        request = 1'b1; operation = READ; addr = 16'h0080;
        step();
        request = 1'b0; operation = NOP;
        check("pend_first_evict", evict, 1'b1);
        check("pend_first_addr", evict_addr, 16'h5500);
        for (int i = 0; i < 6; i++) begin
            step();
            check("pend_no_valid", valid, 1'b0);
        end
        check_counts("pend");

        // Reset two cycles into a WRITE aborts it.
        request = 1'b1; operation = WRITE; addr = 16'h00C0; d_in = '1;
        step();
        request = 1'b0; operation = NOP;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_rd = 0; model_wr = 0; model_dout = '0;
        check("abort_state", dbg_state, IDLE);
        check("abort_dout", d_out, '0);
        check_counts("abort");
        for (int i = 0; i < 6; i++) begin
            step();
            check("abort_no_valid", valid, 1'b0);
        end
        do_op("rdC0", READ, 16'h00C0, '0, 1, -1, '0, -1, '0);
        check("rdC0_zero", d_out, '0);
        check("rdC0_wr0", wr_count, 16'd0);

        // Aliasing: upper address bits are ignored.
        do_op("alias_wr", WRITE, 16'hF440, 64'hDEAD_BEEF_0000_1111, 1, -1, '0, -1, '0);
        do_op("alias_rd", READ, 16'h0040, '0, 2, -1, '0, -1, '0);
        check("alias_data", d_out, 64'hDEAD_BEEF_0000_1111);

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            rop = ($urandom_range(0, 1) == 0) ? READ : WRITE;
            ra  = AW'($urandom_range(0, 16'hFFFF));
            rd  = {$urandom, $urandom};
            rh  = $urandom_range(1, 8);
            ri  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, LAT + 1) : -1;
            ia  = AW'($urandom_range(0, 16'hFFFF));
            do_op("rand", rop, ra, rd, rh, ri, ia, -1, '0);
            if (ri >= 0) expect_evict("rand", ia);
        end

        // Saturation: start the counters just below the ceiling.
        force dut.wr_cnt_q = 16'hFFFE;
        force dut.rd_cnt_q = 16'hFFFE;
        #1;
        release dut.wr_cnt_q;
        release dut.rd_cnt_q;
        model_wr = 65534; model_rd = 65534;
        do_op("sat_wr1", WRITE, 16'h0200, 64'h1, 1, -1, '0, -1, '0);
        do_op("sat_wr2", WRITE, 16'h0240, 64'h2, 1, -1, '0, -1, '0);
        check("sat_wr_ffff", wr_count, 16'hFFFF);
        do_op("sat_rd1", READ, 16'h0200, '0, 1, -1, '0, -1, '0);
        do_op("sat_rd2", READ, 16'h0240, '0, 1, -1, '0, -1, '0);
        check("sat_rd_ffff", rd_count, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
